// File: rtl/stdp_train_sched.sv
// stdp_train_sched: steps STDP training through every neuron/image pair for a number of epochs,
// cutting a neuron short once its weight sweep has completed STOP_COUNT times.
module stdp_train_sched #(
    parameter int IMAGE_NUM  = 9,
    parameter int TRAIN_NUM  = 6,
    parameter int ADDR_W     = 8,
    parameter int LAST_ADDR  = 143,
    parameter int STOP_COUNT = 2,
    parameter int PULSE_CYC  = 1000,
    parameter int SETTLE_CYC = 90000,
    parameter int EPOCHS     = 6
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        START,
    input  logic                        ABORT,
    input  logic [TRAIN_NUM*ADDR_W-1:0] TX_ADDR,
    output logic [IMAGE_NUM:0]          IMAGE,
    output logic [TRAIN_NUM-1:0]        NEURON,
    output logic                        BTN,
    output logic                        EN_STDP,
    output logic                        EN_PULSE,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        EARLY,
    output logic [7:0]                  EPOCH
);
    localparam int IMW  = IMAGE_NUM + 1;
    localparam int IW   = TRAIN_NUM > 1 ? $clog2(TRAIN_NUM) : 1;
    localparam int CMAX = PULSE_CYC > SETTLE_CYC ? PULSE_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = $clog2(STOP_COUNT + 1);

    typedef enum logic [2:0] {IDLE, PRESENT, SETTLE, NEXT, FIN} state_t;

    state_t               state, state_n;
    logic [IW-1:0]        idx, idx_n;
    logic [7:0]           epoch_n;
    logic [CW-1:0]        cyc, cyc_n;
    logic [SW-1:0]        sw_cnt, sw_cnt_n;
    logic [TRAIN_NUM-1:0] match, match_prev;
    logic                 active, sweep, stop, early_n, on_n;

    always_comb begin
        for (int i = 0; i < TRAIN_NUM; i++)
            match[i] = TX_ADDR[i*ADDR_W +: ADDR_W] == ADDR_W'(LAST_ADDR);
    end

    assign active = state == PRESENT || state == SETTLE;
    assign sweep  = match[idx] & ~match_prev[idx];
    assign stop   = sw_cnt == SW'(STOP_COUNT);
    assign on_n   = state_n == PRESENT || state_n == SETTLE;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        epoch_n  = EPOCH;
        cyc_n    = cyc;
        early_n  = 1'b0;
        sw_cnt_n = !active ? '0 : (sweep && !stop) ? sw_cnt + 1'b1 : sw_cnt;
        case (state)
            IDLE: if (START) begin
                state_n = PRESENT;
                idx_n   = '0;
                epoch_n = '0;
                cyc_n   = '0;
            end
            PRESENT: begin
                state_n = stop ? NEXT : cyc == CW'(PULSE_CYC - 1) ? SETTLE : PRESENT;
                early_n = stop;
                cyc_n   = state_n == PRESENT ? cyc + 1'b1 : '0;
            end
            SETTLE: begin
                state_n = stop || cyc == CW'(SETTLE_CYC - 1) ? NEXT : SETTLE;
                early_n = stop;
                cyc_n   = state_n == SETTLE ? cyc + 1'b1 : '0;
            end
            NEXT: begin
                cyc_n = '0;
                if (idx != IW'(TRAIN_NUM - 1)) begin
                    idx_n   = idx + 1'b1;
                    state_n = PRESENT;
                end else begin
                    idx_n   = '0;
                    state_n = EPOCH != 8'(EPOCHS - 1) ? PRESENT : FIN;
                    epoch_n = EPOCH != 8'(EPOCHS - 1) ? EPOCH + 1'b1 : EPOCH;
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // abort overrides every transition and suppresses any pending pulse
        if (ABORT) begin
            state_n  = IDLE;
            idx_n    = '0;
            epoch_n  = '0;
            cyc_n    = '0;
            sw_cnt_n = '0;
            early_n  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            idx        <= '0;
            cyc        <= '0;
            sw_cnt     <= '0;
            match_prev <= '0;
            IMAGE      <= '0;
            NEURON     <= '0;
            BTN        <= 1'b0;
            EN_STDP    <= 1'b0;
            EN_PULSE   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            EARLY      <= 1'b0;
            EPOCH      <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cyc        <= cyc_n;
            sw_cnt     <= sw_cnt_n;
            match_prev <= match;
            // outputs are decoded from the next state so they line up with the state register
            IMAGE      <= on_n ? IMW'(1) << idx_n : '0;
            NEURON     <= on_n ? TRAIN_NUM'(1) << idx_n : '0;
            BTN        <= state_n == PRESENT;
            EN_STDP    <= on_n;
            EN_PULSE   <= on_n;
            BUSY       <= state_n != IDLE;
            DONE       <= state_n == FIN;
            EARLY      <= early_n;
            EPOCH      <= epoch_n;
        end
    end
endmodule

// File: tb/tb_stdp_train_sched.sv
// tb_stdp_train_sched: table vectors for IDLE/ABORT handling plus directed sequences for the
// full two-epoch run, early stop, held/foreign sweeps and asynchronous reset.
module tb_stdp_train_sched;
    logic        CLK = 1'b0;
    logic        RST, START, ABORT;
    logic [47:0] TX_ADDR;
    logic [9:0]  IMAGE;
    logic [5:0]  NEURON;
    logic        BTN, EN_STDP, EN_PULSE, BUSY, DONE, EARLY;
    logic [7:0]  EPOCH;
    int          n_vec = 0;
    int          n_bad = 0;

    typedef struct {
        logic        start;
        logic        abort;
        logic [29:0] exp;
    } vec_t;
    vec_t vt[10];

    stdp_train_sched #(
        .IMAGE_NUM(9), .TRAIN_NUM(6), .ADDR_W(8), .LAST_ADDR(143),
        .STOP_COUNT(2), .PULSE_CYC(4), .SETTLE_CYC(20), .EPOCHS(2)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .TX_ADDR(TX_ADDR),
        .IMAGE(IMAGE), .NEURON(NEURON), .BTN(BTN), .EN_STDP(EN_STDP), .EN_PULSE(EN_PULSE),
        .BUSY(BUSY), .DONE(DONE), .EARLY(EARLY), .EPOCH(EPOCH)
    );

    always #5 CLK = ~CLK;

    function automatic logic [29:0] mk(input logic [9:0] img, input logic [5:0] neu, input logic btn,
                                       input logic en, input logic busy, input logic done,
                                       input logic early, input logic [7:0] ep);
        return {img, neu, btn, en, en, busy, done, early, ep};
    endfunction

    function automatic logic [29:0] outs();
        return {IMAGE, NEURON, BTN, EN_STDP, EN_PULSE, BUSY, DONE, EARLY, EPOCH};
    endfunction

    // k counts cycles from the first PRESENT cycle; each neuron takes 4 + 20 + 1 cycles
    function automatic logic [29:0] run_exp(input int k);
        int p;
        int n;
        p = k % 25;
        n = (k % 150) / 25;
        if (k >= 300)
            return mk(10'd0, 6'd0, 1'b0, 1'b0, k == 300, k == 300, 1'b0, 8'd1);
        return mk(p < 24 ? 10'd1 << n : 10'd0, p < 24 ? 6'd1 << n : 6'd0, p < 4, p < 24,
                  1'b1, 1'b0, 1'b0, 8'(k / 150));
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [29:0] act, input logic [29:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic begin_run();
        START = 1'b1;
        step();
        START = 1'b0;
        chk("run_k0", outs(), run_exp(0));
    endtask

    task automatic abort_run();
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("abort", outs(), 30'd0);
    endtask

    initial begin
        RST = 1'b1;
        START = 1'b0;
        ABORT = 1'b0;
        TX_ADDR = '0;
        vt[0] = '{1'b0, 1'b0, 30'd0};
        vt[1] = '{1'b1, 1'b1, 30'd0};
        vt[2] = '{1'b1, 1'b0, mk(10'd1, 6'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0)};
        vt[3] = '{1'b0, 1'b0, mk(10'd1, 6'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0)};
        vt[4] = '{1'b0, 1'b0, mk(10'd1, 6'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0)};
        vt[5] = '{1'b0, 1'b0, mk(10'd1, 6'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0)};
        vt[6] = '{1'b0, 1'b0, mk(10'd1, 6'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0)};
        vt[7] = '{1'b1, 1'b0, mk(10'd1, 6'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0)};
        vt[8] = '{1'b0, 1'b1, 30'd0};
        vt[9] = '{1'b0, 1'b0, 30'd0};
        repeat (2) @(posedge CLK);
        #1;
        chk("reset", outs(), 30'd0);
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            START = vt[i].start;
            ABORT = vt[i].abort;
            step();
            chk($sformatf("vec%0d", i), outs(), vt[i].exp);
        end
        START = 1'b0;
        ABORT = 1'b0;

        // complete two-epoch run with no sweeps
        begin_run();
        for (int k = 1; k <= 301; k++) begin
            step();
            chk($sformatf("run_k%0d", k), outs(), run_exp(k));
        end

        // two separate sweeps of neuron 2 during its SETTLE
        begin_run();
        for (int k = 1; k <= 56; k++) begin
            step();
            chk($sformatf("es_k%0d", k), outs(), run_exp(k));
        end
        TX_ADDR[16 +: 8] = 8'd143;
        step();
        chk("es_hit1", outs(), run_exp(57));
        TX_ADDR[16 +: 8] = 8'd0;
        step();
        chk("es_gap", outs(), run_exp(58));
        TX_ADDR[16 +: 8] = 8'd143;
        step();
        chk("es_hit2", outs(), run_exp(59));
        TX_ADDR[16 +: 8] = 8'd0;
        step();
        chk("es_early", outs(), mk(10'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0));
        step();
        chk("es_next", outs(), mk(10'b1000, 6'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        abort_run();

        // held address counts once; neuron 4 sweeps are ignored while idx=2
        begin_run();
        for (int k = 1; k <= 56; k++) begin
            step();
            chk($sformatf("hold_k%0d", k), outs(), run_exp(k));
        end
        for (int j = 0; j < 10; j++) begin
            TX_ADDR[16 +: 8] = 8'd143;
            TX_ADDR[32 +: 8] = (j % 2 == 0) ? 8'd143 : 8'd0;
            step();
            chk($sformatf("hold_k%0d", 57 + j), outs(), run_exp(57 + j));
        end
        TX_ADDR = '0;
        for (int k = 67; k <= 75; k++) begin
            step();
            chk($sformatf("hold_k%0d", k), outs(), run_exp(k));
        end
        abort_run();

        // asynchronous reset between edges during PRESENT
        begin_run();
        step();
        chk("rst_pre", outs(), run_exp(1));
        #2;
        RST = 1'b1;
        #1;
        chk("rst_async", outs(), 30'd0);
        step();
        RST = 1'b0;
        step();
        chk("rst_idle", outs(), 30'd0);
        begin_run();
        step();
        chk("rst_restart", outs(), run_exp(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
